// File: rtl/tap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tap_pkg
//  Description : Shared definitions for the TAP FIFO encoder. Holds the bit
//                positions of the fields inside a scan frame and a helper
//                that derives the frame width from the payload width.
//                Frame layout (shifted out LSB first):
//                  bit 0                  word_valid
//                  bit 1                  overflow
//                  bits FRAME_WIDTH-1:2   payload data
//  Revision    : 1.0 - initial release
// ============================================================================
package tap_pkg;

    localparam int VALID_BIT = 0;
    localparam int OVF_BIT   = 1;
    localparam int DATA_LSB  = 2;

    // One word_valid bit plus one overflow bit wrap every payload word.
    function automatic int frame_width(input int data_width);
        return data_width + DATA_LSB;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tap_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tap_sync_fifo
//  Description : Single-clock FIFO with a registered occupancy counter.
//                The caller decides when push/pop are legal; the FIFO
//                simply performs them. The head word is presented
//                combinationally so it can be framed on the same edge that
//                pops it.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset (pointers/level)
//                push       - write i_wr_data at the tail
//                pop        - discard the head word
//                i_wr_data  - word to write
//                o_head     - word at the head of the queue
//                full/empty - occupancy flags
//                level      - number of stored words
//  Revision    : 1.0 - initial release
// ============================================================================
module tap_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    output logic [DATA_WIDTH-1:0]        o_head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0]    r_level;

    // Storage carries no reset; stale words are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign full   = (r_level == c_LVL_W'(DEPTH));
    assign empty  = (r_level == '0);
    assign level  = r_level;

endmodule
`default_nettype wire

// File: rtl/tap_fifo_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tap_fifo_encoder
//  Description : Queues parallel words in a small FIFO and serialises them
//                through a JTAG user data register. Capture-DR loads one
//                frame (head word, sticky overflow flag, word_valid) into
//                the shift register; Shift-DR moves it out on tdo LSB first,
//                back-filling with ones. With STREAM=1 the next frame is
//                loaded automatically after the last bit so several frames
//                can be read in one DR scan.
//  Ports       : tck              - TAP clock, rising edge
//                test_logic_reset - synchronous active-high reset
//                ir_is_user       - user instruction selected in the IR
//                capture_dr       - TAP in Capture-DR
//                shift_dr         - TAP in Shift-DR
//                tdo              - serial data out (shift register LSB)
//                data / valid     - word to enqueue and its request
//                ready            - FIFO not full
//                level            - FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module tap_fifo_encoder
    import tap_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int STREAM     = 0
) (
    input  logic                         tck,
    input  logic                         test_logic_reset,
    input  logic                         ir_is_user,
    input  logic                         capture_dr,
    input  logic                         shift_dr,
    output logic                         tdo,
    input  logic [DATA_WIDTH-1:0]        data,
    input  logic                         valid,
    output logic                         ready,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int c_FRAME_WIDTH = frame_width(DATA_WIDTH);
    localparam int c_CNT_W       = $clog2(c_FRAME_WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_FRAME_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(c_FRAME_WIDTH);

    logic [c_FRAME_WIDTH-1:0] r_shift_reg;
    logic [c_CNT_W-1:0]       r_bit_cnt;
    logic                     r_overflow;

    logic                     w_full;
    logic                     w_empty;
    logic [DATA_WIDTH-1:0]    w_head;
    logic                     w_wrap;
    logic                     w_load;
    logic                     w_shift;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;
    logic [c_FRAME_WIDTH-1:0] w_frame;

    // In streaming mode the last bit of a frame is replaced by a reload.
    generate
        if (STREAM != 0) begin : g_stream
            assign w_wrap = (r_bit_cnt == c_CNT_LAST);
        end else begin : g_single
            assign w_wrap = 1'b0;
        end
    endgenerate

    // capture_dr outranks shift_dr; both are ignored without the user IR.
    assign w_load  = ir_is_user & (capture_dr | (shift_dr & w_wrap));
    assign w_shift = ir_is_user & ~capture_dr & shift_dr & ~w_wrap;
    assign w_pop   = w_load & ~w_empty;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign w_push  = valid & (~w_full | w_pop);
    assign w_drop  = valid & w_full & ~w_pop;

    always_comb begin
        w_frame            = '0;
        w_frame[VALID_BIT] = ~w_empty;
        w_frame[OVF_BIT]   = r_overflow;
        if (!w_empty) begin
            w_frame[c_FRAME_WIDTH-1:DATA_LSB] = w_head;
        end
    end

    always_ff @(posedge tck) begin
        if (test_logic_reset) begin
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
            r_overflow  <= 1'b0;
        end else if (w_load) begin
            r_shift_reg <= w_frame;
            r_bit_cnt   <= '0;
            // Reporting clears the flag, unless a word is lost right now.
            r_overflow  <= w_drop;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_shift) begin
                r_shift_reg <= {1'b1, r_shift_reg[c_FRAME_WIDTH-1:1]};
                if (r_bit_cnt != c_CNT_SAT) begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    tap_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (tck),
        .rst       (test_logic_reset),
        .push      (w_push),
        .pop       (w_pop),
        .i_wr_data (data),
        .o_head    (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (level)
    );

    assign tdo   = r_shift_reg[0];
    assign ready = ~w_full;

endmodule
`default_nettype wire

// File: tb/tb_tap_fifo_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tap_fifo_encoder
//  Description : Self-checking bench for tap_fifo_encoder. One instance with
//                STREAM=0 and one with STREAM=1 share the stimulus. A queue
//                model per instance predicts tdo, ready and level, and
//                literal expectations pin the frame encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tap_fifo_encoder;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int FW    = 10;

    logic       tck = 1'b0;
    logic       rst, user, cap, sh, valid;
    logic [7:0] data;
    logic       tdo0, tdo1, ready0, ready1;
    logic [2:0] level0, level1;

    int checks = 0;
    int errors = 0;

    tap_fifo_encoder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STREAM(0)) u_single (
        .tck(tck), .test_logic_reset(rst), .ir_is_user(user), .capture_dr(cap),
        .shift_dr(sh), .tdo(tdo0), .data(data), .valid(valid), .ready(ready0),
        .level(level0)
    );

    tap_fifo_encoder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STREAM(1)) u_stream (
        .tck(tck), .test_logic_reset(rst), .ir_is_user(user), .capture_dr(cap),
        .shift_dr(sh), .tdo(tdo1), .data(data), .valid(valid), .ready(ready1),
        .level(level1)
    );

    always #5 tck = ~tck;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: queued words, sticky overflow, the frame last loaded and
    // how many bits of it have been shifted (tdo = frame[k], ones after).
    logic [7:0]    mq [2][DEPTH];
    int            mn [2];
    logic          movf [2];
    logic [FW-1:0] mf [2];
    int            mk [2];
    bit            live = 1'b0;

    task automatic model_step(input int s, input bit stream);
        bit full, empty, load, dshift, pop, push, drop;
        if (rst) begin
            mn[s] = 0; movf[s] = 1'b0; mf[s] = '0; mk[s] = 0;
            return;
        end
        full   = (mn[s] == DEPTH);
        empty  = (mn[s] == 0);
        load   = user && (cap || (sh && stream && mk[s] == FW-1));
        dshift = user && !cap && sh && !load;
        pop    = load && !empty;
        push   = valid && (!full || pop);
        drop   = valid && full && !pop;
        if (load) begin
            mf[s] = empty ? {8'h00, movf[s], 1'b0} : {mq[s][0], movf[s], 1'b1};
            if (pop) begin
                for (int i = 0; i < DEPTH-1; i++) mq[s][i] = mq[s][i+1];
                mn[s]--;
            end
            mk[s]   = 0;
            movf[s] = drop;
        end else begin
            if (drop) movf[s] = 1'b1;
            if (dshift && mk[s] < FW) mk[s]++;
        end
        if (push) begin
            mq[s][mn[s]] = data;
            mn[s]++;
        end
    endtask

    function automatic logic m_tdo(input int s);
        logic [FW-1:0] f;
        f = mf[s];
        return (mk[s] < FW) ? f[mk[s]] : 1'b1;
    endfunction

    always @(posedge tck) begin
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        live <= 1'b1;
    end

    always @(negedge tck) begin
        if (live) begin
            chk("single_tdo",   tdo0,   m_tdo(0));
            chk("single_ready", ready0, (mn[0] < DEPTH));
            chk("single_level", level0, mn[0]);
            chk("stream_tdo",   tdo1,   m_tdo(1));
            chk("stream_ready", ready1, (mn[1] < DEPTH));
            chk("stream_level", level1, mn[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit r, input bit u, input bit c, input bit s,
                        input bit v, input logic [7:0] d);
        rst = r; user = u; cap = c; sh = s; valid = v; data = d;
        @(posedge tck);
        @(negedge tck);
    endtask

    task automatic do_idle();            step(0, 0, 0, 0, 0, 8'h00); endtask
    task automatic do_push(input logic [7:0] d); step(0, 0, 0, 0, 1, d); endtask
    task automatic do_capture();         step(0, 1, 1, 0, 0, 8'h00); endtask
    task automatic do_shift();           step(0, 1, 0, 1, 0, 8'h00); endtask
    task automatic do_reset();           step(1, 0, 0, 0, 0, 8'h00); endtask

    initial begin
        logic [9:0]  e34;
        logic [29:0] e38;
        e34 = 10'b1010010101;                              // {0xA5, 0, 1}
        e38 = {10'h000, 10'b0000001001, 10'b0000000101};   // {1,0,1},{2,0,1},{0,0,0}

        do_reset();
        do_reset();
        chk("reset_tdo",   tdo0,   1'b0);
        chk("reset_ready", ready0, 1'b1);
        chk("reset_level", level0, 3'd0);

        // Single word through one frame.
        do_push(8'hA5);
        chk("a5_level_pushed", level0, 3'd1);
        do_capture();
        chk("a5_level_popped", level0, 3'd0);
        for (int i = 0; i < FW; i++) begin
            if (i == 5) begin
                step(0, 0, 0, 1, 0, 8'h00);   // shift without user IR holds
                chk("hold_tdo", tdo0, e34[5]);
            end
            chk("a5_bit", tdo0, e34[i]);
            do_shift();
        end
        chk("a5_fill_one", tdo0, 1'b1);

        // Empty FIFO frame.
        do_capture();
        for (int i = 0; i < FW; i++) begin
            chk("empty_bit", tdo0, 1'b0);
            do_shift();
        end
        chk("empty_fill_one", tdo0, 1'b1);

        // Overflow: fifth word dropped and reported once.
        for (int i = 0; i < 5; i++) begin
            do_push(8'h11 + 8'(i));
            if (i == 3) chk("ovf_ready_low", ready0, 1'b0);
        end
        chk("ovf_level_full", level0, 3'd4);
        do_capture();
        chk("ovf_frame1_valid", tdo0, 1'b1);
        do_shift();
        chk("ovf_frame1_flag", tdo0, 1'b1);
        for (int i = 0; i < FW-1; i++) do_shift();
        do_capture();
        chk("ovf_frame2_valid", tdo0, 1'b1);
        do_shift();
        chk("ovf_frame2_flag", tdo0, 1'b0);
        chk("ovf_level_after", level0, 3'd2);

        // Full FIFO, push together with capture.
        do_push(8'h21);
        do_push(8'h22);
        chk("fullcap_level_before", level0, 3'd4);
        step(0, 1, 1, 0, 1, 8'h33);
        chk("fullcap_level", level0, 3'd4);
        do_shift();
        do_capture();
        do_shift();
        chk("fullcap_no_ovf", tdo0, 1'b0);

        // Reset in the middle of a frame.
        do_capture();
        do_shift(); do_shift(); do_shift();
        do_reset();
        chk("midrst_tdo",   tdo0,   1'b0);
        chk("midrst_level", level0, 3'd0);
        chk("midrst_ready", ready0, 1'b1);
        do_capture();
        chk("midrst_invalid", tdo0, 1'b0);
        do_shift();
        chk("midrst_ovf", tdo0, 1'b0);
        do_idle();

        // Streaming three frames in one scan.
        do_reset();
        do_push(8'h01);
        do_push(8'h02);
        chk("stream_level_before", level1, 3'd2);
        do_capture();
        for (int i = 0; i < 3*FW; i++) begin
            chk("stream_bit", tdo1, e38[i]);
            do_shift();
        end
        chk("stream_level_after", level1, 3'd0);
        do_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
